// File: rtl/reg_bus_master_pkg.sv
// reg_bus_master_pkg: shared state encoding, phase counter width and default bus timing
package reg_bus_master_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;
  localparam int PHASE_W = 4;
  localparam int DEF_SETUP = 1;
  localparam int DEF_STROBE = 2;
  localparam int DEF_HOLD = 1;
endpackage

// File: rtl/bus_phase_timer.sv
// bus_phase_timer: loadable down-counter; last is high in the final cycle of a phase
module bus_phase_timer
  import reg_bus_master_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic               last
);
  logic [PHASE_W-1:0] count;
  assign last = count == '0;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else count <= load ? load_val : (last ? count : count - 1'b1);
endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master: single-beat valid/ready initiator for the async register bus with setup/strobe/hold phases
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int SETUP_CYCLES  = DEF_SETUP,
  parameter int STROBE_CYCLES = DEF_STROBE,
  parameter int HOLD_CYCLES   = DEF_HOLD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  bus_en,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [1:0]            bus_be,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  output logic                  bus_data_oe,
  input  logic [DATA_WIDTH-1:0] bus_data_in
);
  state_t state, state_n;
  logic load, last, accept, is_write, cap;
  logic ready_n, en_n, rd_n, wr_n, oe_n, resp_n;
  logic [PHASE_W-1:0] load_val;
  assign accept = req_valid && req_ready;
  bus_phase_timer u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .last(last)
  );
  always_comb begin
    state_n = state;
    load = 1'b0;
    load_val = '0;
    cap = 1'b0;
    ready_n = req_ready;
    en_n = bus_en;
    rd_n = bus_rd;
    wr_n = bus_wr;
    oe_n = bus_data_oe;
    resp_n = 1'b0;
    case (state)
      IDLE: if (accept) begin
        load = 1'b1;
        ready_n = 1'b0;
        en_n = 1'b1;
        oe_n = req_write;
        state_n = SETUP_CYCLES == 0 ? STROBE : SETUP;
        load_val = SETUP_CYCLES == 0 ? PHASE_W'(STROBE_CYCLES - 1) : PHASE_W'(SETUP_CYCLES - 1);
        rd_n = SETUP_CYCLES == 0 && !req_write;
        wr_n = SETUP_CYCLES == 0 && req_write;
      end
      SETUP: if (last) begin
        state_n = STROBE;
        load = 1'b1;
        load_val = PHASE_W'(STROBE_CYCLES - 1);
        rd_n = !is_write;
        wr_n = is_write;
      end
      STROBE: if (last) begin
        state_n = HOLD;
        load = 1'b1;
        load_val = PHASE_W'(HOLD_CYCLES - 1);
        rd_n = 1'b0;
        wr_n = 1'b0;
        cap = !is_write;
      end
      HOLD: if (last) begin
        state_n = IDLE;
        en_n = 1'b0;
        oe_n = 1'b0;
        ready_n = 1'b1;
        resp_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      bus_en <= 1'b0;
      bus_rd <= 1'b0;
      bus_wr <= 1'b0;
      bus_data_oe <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_data_out <= '0;
      is_write <= 1'b0;
    end else begin
      state <= state_n;
      req_ready <= ready_n;
      bus_en <= en_n;
      bus_rd <= rd_n;
      bus_wr <= wr_n;
      bus_data_oe <= oe_n;
      resp_valid <= resp_n;
      if (accept) begin
        bus_addr <= req_addr;
        bus_be <= req_be;
        bus_data_out <= req_wdata;
        is_write <= req_write;
      end
      if (cap) resp_rdata <= bus_data_in;
    end
  end
endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed bench with a cycle-position model of the bus master and a register file on the bus
module tb_reg_bus_master;
  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;
  localparam int P = 1 + S + T + H;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_be = '0;
  logic req_ready, resp_valid, bus_en, bus_rd, bus_wr, bus_data_oe;
  logic [15:0] resp_rdata, bus_addr, bus_data_out, bus_data_in;
  logic [1:0] bus_be;
  logic v2 = 1'b0;
  logic ready2, resp2, en2, rd2, wr2, oe2;
  logic [15:0] rdata2, addr2, dout2;
  logic [1:0] be2;
  logic [15:0] din2 = 16'h00A5;
  int total = 0, bad = 0, cyc = 0;
  bit chk_on = 1'b0;
  logic [15:0] rf [16] = '{default: 16'h0};
  logic [15:0] mmem [16] = '{default: 16'h0};
  int pos = 0;
  logic m_resp = 1'b0, m_w = 1'b0;
  logic [15:0] m_a = '0, m_d = '0, m_rd = '0;
  logic [1:0] m_b = '0;
  int acc_cyc = 0, last_resp = 0, prev_resp = 0;
  always #5 clk = ~clk;
  reg_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .bus_en(bus_en), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_be(bus_be),
    .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in)
  );
  reg_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_ready(ready2), .req_write(1'b1),
    .req_addr(16'h0002), .req_be(2'b11), .req_wdata(16'h1234), .resp_valid(resp2),
    .resp_rdata(rdata2), .bus_en(en2), .bus_rd(rd2), .bus_wr(wr2), .bus_be(be2),
    .bus_addr(addr2), .bus_data_out(dout2), .bus_data_oe(oe2), .bus_data_in(din2)
  );
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  assign bus_data_in = rf[bus_addr[3:0]];
  initial forever begin
    @(negedge bus_wr);
    rf[bus_addr[3:0]] = merge(rf[bus_addr[3:0]], bus_data_out, bus_be);
  end
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      pos = 0; m_resp = 1'b0; m_w = 1'b0; m_a = '0; m_d = '0; m_b = '0; m_rd = '0;
    end else begin
      m_resp = 1'b0;
      if (pos != 0) begin
        if (!m_w && pos == S + T) m_rd = mmem[m_a[3:0]];
        if (pos == P - 1) begin
          pos = 0;
          m_resp = 1'b1;
          if (m_w) mmem[m_a[3:0]] = merge(mmem[m_a[3:0]], m_d, m_b);
        end else pos++;
      end else if (req_valid) begin
        pos = 1; m_w = req_write; m_a = req_addr; m_b = req_be; m_d = req_wdata;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("ctl", 32'({req_ready, resp_valid, bus_en, bus_rd, bus_wr, bus_data_oe}),
          32'({pos == 0, m_resp, pos != 0, pos >= S + 1 && pos <= S + T && !m_w,
               pos >= S + 1 && pos <= S + T && m_w, pos != 0 && m_w}));
      chk("addr", 32'(bus_addr), 32'(m_a));
      chk("be", 32'(bus_be), 32'(m_b));
      chk("wdata", 32'(bus_data_out), 32'(m_d));
      chk("rdata", 32'(resp_rdata), 32'(m_rd));
      if (resp_valid) begin
        prev_resp = last_resp;
        last_resp = cyc;
      end
    end
  end
  task automatic do_req(input logic w, input logic [15:0] a, input logic [1:0] b, input logic [15:0] d, input bit keep);
    int n;
    bit acc;
    req_valid = 1'b1; req_write = w; req_addr = a; req_be = b; req_wdata = d;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    chk("accept", 32'(acc), 32'd1);
    acc_cyc = cyc;
    if (!keep) req_valid = 1'b0;
  endtask
  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    chk("resp_wait", 32'(resp_valid), 32'd1);
  endtask
  task automatic sample5(output logic [4:0] en_v, output logic [4:0] rd_v, output logic [4:0] wr_v,
                         output logic [4:0] oe_v, output logic [4:0] rs_v, output logic [1:0] be_mid);
    be_mid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      en_v[c] = bus_en; rd_v[c] = bus_rd; wr_v[c] = bus_wr; oe_v[c] = bus_data_oe; rs_v[c] = resp_valid;
      if (c == 1) be_mid = bus_be;
    end
  endtask
  initial begin
    logic [4:0] ev, rv, wv, ov, sv;
    logic [1:0] bm;
    logic [6:0] e2, w2, s2;
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("rst_ctl", 32'({req_ready, resp_valid, bus_en, bus_rd, bus_wr, bus_data_oe}), 32'b100000);
    chk("rst_rdata", 32'(resp_rdata), 32'h0);
    reset = 1'b0;
    do_req(1'b1, 16'h0003, 2'b11, 16'hBEEF, 1'b0);
    sample5(ev, rv, wv, ov, sv, bm);
    chk("wr_wr", 32'(wv), 32'b00110);
    chk("wr_en", 32'(ev), 32'b01111);
    chk("wr_oe", 32'(ov), 32'b01111);
    chk("wr_resp", 32'(sv), 32'b10000);
    chk("wr_rd", 32'(rv), 32'b00000);
    chk("rf3", 32'(rf[3]), 32'hBEEF);
    do_req(1'b0, 16'h0003, 2'b11, 16'h0000, 1'b0);
    sample5(ev, rv, wv, ov, sv, bm);
    chk("rd_rd", 32'(rv), 32'b00110);
    chk("rd_oe", 32'(ov), 32'b00000);
    chk("rd_resp", 32'(sv), 32'b10000);
    chk("rd_data", 32'(resp_rdata), 32'hBEEF);
    do_req(1'b1, 16'h0003, 2'b01, 16'h12AB, 1'b0);
    sample5(ev, rv, wv, ov, sv, bm);
    chk("bw_be", 32'(bm), 32'b01);
    do_req(1'b0, 16'h0003, 2'b11, 16'h0000, 1'b0);
    wait_resp();
    chk("bw_read", 32'(resp_rdata), 32'hBEAB);
    @(negedge clk);
    do_req(1'b0, 16'h0003, 2'b11, 16'h0000, 1'b1);
    seen = acc_cyc;
    do_req(1'b0, 16'h0007, 2'b11, 16'h0000, 1'b0);
    chk("b2b_accept_gap", 32'(acc_cyc - seen), 32'd5);
    wait_resp();
    chk("b2b_resp_gap", 32'(last_resp - prev_resp), 32'd5);
    chk("b2b_rdata", 32'(resp_rdata), 32'h0);
    do_req(1'b1, 16'h0005, 2'b11, 16'h5555, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_wr", 32'(bus_wr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ctl", 32'({req_ready, bus_en, bus_wr, bus_data_oe, resp_valid}), 32'b10000);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    do_req(1'b0, 16'h0003, 2'b11, 16'h0000, 1'b0);
    wait_resp();
    chk("post_abort_read", 32'(resp_rdata), 32'hBEAB);
    @(negedge clk);
    v2 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      e2[c] = en2; w2[c] = wr2; s2[c] = resp2;
      if (c == 5) v2 = 1'b0;
    end
    chk("fast_wr", 32'(w2), 32'b0001001);
    chk("fast_en", 32'(e2), 32'b0011011);
    chk("fast_resp", 32'(s2), 32'b0100100);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
